merge_driver: RTL and testbench
===============================

MERGE_DRIVER -- requirements
Module: merge_driver

Interface
REQ-001 Parameter CNT_W, default 10; width of length fields and element counters.
REQ-002 Parameter SETTLE_CYC, default 4; idle cycles between the last FIFO write and merge_start assertion.
REQ-003 clock  in  1  clock; all logic on rising edge.
REQ-004 reset  in  1  reset, synchronous, active-high.
REQ-005 cfg_go  in  1  job request; sampled only in IDLE.
REQ-006 cfg_len1 / cfg_len2  in  CNT_W each  element counts for run 1 and run 2; captured on accepted cfg_go.
REQ-007 in_valid  in  1 / in_data  in  32 / in_ready  out  1  input element stream: run 1 first, then run 2.
REQ-008 fifo_wr_data  out  32 / fifo1_wr_en  out  1 / fifo2_wr_en  out  1  write port to the merge core input FIFOs.
REQ-009 merge_start  out  1 / merge_done  in  1  merge core level handshake.
REQ-010 merged_rd_en  out  1 / merged_rd_data  in  32  merged FIFO read port; data is valid the cycle after merged_rd_en.
REQ-011 out_valid  out  1 / out_data  out  32 / out_last  out  1 / out_ready  in  1  merged output stream.
REQ-012 busy  out  1 high whenever state != IDLE; job_done  out  1 single-cycle completion pulse.

Function
REQ-013 States SHALL be IDLE, LOAD1, LOAD2, SETTLE, START, WAIT_DONE, RD_REQ, RD_CAP, OUT, FINISH.
REQ-014 IDLE: on cfg_go, capture lengths and total = len1+len2 (CNT_W+1 bits), then go to LOAD1 if len1>0, else LOAD2 if len2>0, else SETTLE.
REQ-015 in_ready SHALL be 1 only in LOAD1/LOAD2; one element is accepted per cycle with in_valid&&in_ready.
REQ-016 Accepted element SHALL appear on fifo_wr_data with fifo1_wr_en (LOAD1) or fifo2_wr_en (LOAD2) exactly one cycle later, one-cycle pulse; both enables are never high together.
REQ-017 LOAD1 -> LOAD2 (len2>0) or SETTLE when the len1-th element is accepted; LOAD2 -> SETTLE when the len2-th element is accepted.
REQ-018 SETTLE: hold SETTLE_CYC cycles counted from the last write-enable pulse, then go to START.
REQ-019 START: if merge_done is high, wait; else assert merge_start and go to WAIT_DONE.
REQ-020 merge_start SHALL stay high from START through WAIT_DONE until merge_done=1 is sampled, then drop on the next edge.
REQ-021 WAIT_DONE on merge_done: go to RD_REQ if total>0, else FINISH.
REQ-022 RD_REQ: merged_rd_en=1 for exactly one cycle -> RD_CAP.
REQ-023 RD_CAP: register merged_rd_data into out_data -> OUT.
REQ-024 OUT: out_valid=1 with out_data held stable until out_ready.
REQ-025 out_last=1 on the total-th element only.
REQ-026 On the OUT handshake: go to RD_REQ if more elements remain, else FINISH.
REQ-027 FINISH: pulse job_done for one cycle on entry, wait for merge_done=0, then go to IDLE.
REQ-028 cfg_go outside IDLE SHALL be ignored, with no length capture.
REQ-029 Element counters SHALL be CNT_W+1 bits and never wrap within a job.
REQ-030 len1+len2 above merge core FIFO depth is unsupported; behaviour is undefined.
REQ-031 out_ready held low SHALL stall indefinitely with no extra merged_rd_en.

Reset
REQ-032 Reset SHALL put the block in IDLE with these outputs 0: in_ready, fifo1_wr_en, fifo2_wr_en, merge_start, merged_rd_en, out_valid, out_last, busy, job_done. out_data and fifo_wr_data SHALL be 0.
REQ-033 Reset mid-job SHALL abandon the job with no further pulses; the merge core shares reset, so no FIFO flush is required.

Verification
REQ-034 len1=3 {1,4,9}, len2=3 {2,3,10}, out_ready=1 -> fifo1 writes 1,4,9 then fifo2 writes 2,3,10; output 1,2,3,4,9,10; out_last on 10; one job_done pulse.
REQ-035 len1=0, len2=2 {7,5} -> no fifo1_wr_en; output 7,5 in order.
REQ-036 len1=0, len2=0 -> merge_start high until merge_done; no merged_rd_en, no out_valid; one job_done pulse.
REQ-037 Run-1 input with in_valid toggling every other cycle, and out_ready low 5 cycles on element 2 -> out_data stable while stalled; exactly total merged_rd_en pulses; output matches reference model.
REQ-038 Reset asserted in WAIT_DONE, then new job len1=1 {8}, len2=1 {6} -> clean restart; output 6,8.
REQ-039 cfg_go pulsed during LOAD2 with different lengths -> ignored; job completes with the original lengths.

Source files
------------

// File: rtl/merge_driver.sv
// rtl/merge_driver.sv - sequences two sorted runs into the merge core FIFOs and streams the merged result out
// Single FSM with registered outputs; element counters are one bit wider than the length fields.
module merge_driver #(
    parameter int CNT_W      = 10,
    parameter int SETTLE_CYC = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cfg_go,
    input  logic [CNT_W-1:0] cfg_len1,
    input  logic [CNT_W-1:0] cfg_len2,
    input  logic             in_valid,
    input  logic [31:0]      in_data,
    output logic             in_ready,
    output logic [31:0]      fifo_wr_data,
    output logic             fifo1_wr_en,
    output logic             fifo2_wr_en,
    output logic             merge_start,
    input  logic             merge_done,
    output logic             merged_rd_en,
    input  logic [31:0]      merged_rd_data,
    output logic             out_valid,
    output logic [31:0]      out_data,
    output logic             out_last,
    input  logic             out_ready,
    output logic             busy,
    output logic             job_done
);

    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SET_W-1:0] SET_LAST = (SETTLE_CYC > 1) ? SET_W'(SETTLE_CYC - 1) : '0;

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD1, S_LOAD2, S_SETTLE, S_START,
        S_WAIT_DONE, S_RD_REQ, S_RD_CAP, S_OUT, S_FINISH
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_len1;
    logic [CNT_W-1:0]   r_len2;
    logic [CNT_W:0]     r_total;
    logic [CNT_W:0]     r_cnt;
    logic [SET_W-1:0]   r_settle;

    logic               w_accept;
    logic [CNT_W:0]     w_cnt_inc;
    logic [CNT_W:0]     w_cfg_total;

    assign w_accept    = in_valid && in_ready;
    assign w_cnt_inc   = r_cnt + (CNT_W+1)'(1);
    assign w_cfg_total = {1'b0, cfg_len1} + {1'b0, cfg_len2};

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_len1       <= '0;
            r_len2       <= '0;
            r_total      <= '0;
            r_cnt        <= '0;
            r_settle     <= '0;
            in_ready     <= 1'b0;
            fifo_wr_data <= '0;
            fifo1_wr_en  <= 1'b0;
            fifo2_wr_en  <= 1'b0;
            merge_start  <= 1'b0;
            merged_rd_en <= 1'b0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_last     <= 1'b0;
            busy         <= 1'b0;
            job_done     <= 1'b0;
        end else begin
            fifo1_wr_en  <= 1'b0;
            fifo2_wr_en  <= 1'b0;
            merged_rd_en <= 1'b0;
            job_done     <= 1'b0;
            if (w_accept) begin
                fifo_wr_data <= in_data;
            end

            case (r_state)
                S_IDLE: begin
                    if (cfg_go) begin
                        r_len1   <= cfg_len1;
                        r_len2   <= cfg_len2;
                        r_total  <= w_cfg_total;
                        r_cnt    <= '0;
                        r_settle <= '0;
                        busy     <= 1'b1;
                        if (cfg_len1 != '0) begin
                            r_state  <= S_LOAD1;
                            in_ready <= 1'b1;
                        end else if (cfg_len2 != '0) begin
                            r_state  <= S_LOAD2;
                            in_ready <= 1'b1;
                        end else begin
                            r_state <= S_SETTLE;
                        end
                    end
                end
                S_LOAD1: begin
                    if (w_accept) begin
                        fifo1_wr_en <= 1'b1;
                        if (w_cnt_inc == {1'b0, r_len1}) begin
                            r_cnt <= '0;
                            if (r_len2 != '0) begin
                                r_state <= S_LOAD2;
                            end else begin
                                r_state  <= S_SETTLE;
                                in_ready <= 1'b0;
                            end
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                end
                S_LOAD2: begin
                    if (w_accept) begin
                        fifo2_wr_en <= 1'b1;
                        if (w_cnt_inc == {1'b0, r_len2}) begin
                            r_cnt    <= '0;
                            r_state  <= S_SETTLE;
                            in_ready <= 1'b0;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                end
                // First SETTLE cycle carries the final write pulse, so START lands SETTLE_CYC idle cycles later.
                S_SETTLE: begin
                    if (r_settle == SET_LAST) begin
                        r_settle <= '0;
                        r_state  <= S_START;
                    end else begin
                        r_settle <= r_settle + SET_W'(1);
                    end
                end
                S_START: begin
                    if (!merge_done) begin
                        merge_start <= 1'b1;
                        r_state     <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (merge_done) begin
                        merge_start <= 1'b0;
                        r_cnt       <= '0;
                        if (r_total != '0) begin
                            r_state      <= S_RD_REQ;
                            merged_rd_en <= 1'b1;
                        end else begin
                            r_state  <= S_FINISH;
                            job_done <= 1'b1;
                        end
                    end
                end
                S_RD_REQ: begin
                    r_state <= S_RD_CAP;
                end
                S_RD_CAP: begin
                    out_data  <= merged_rd_data;
                    out_valid <= 1'b1;
                    out_last  <= (w_cnt_inc == r_total);
                    r_state   <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        r_cnt     <= w_cnt_inc;
                        if (w_cnt_inc == r_total) begin
                            r_state  <= S_FINISH;
                            job_done <= 1'b1;
                        end else begin
                            r_state      <= S_RD_REQ;
                            merged_rd_en <= 1'b1;
                        end
                    end
                end
                S_FINISH: begin
                    if (!merge_done) begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_merge_driver.sv
// tb/tb_merge_driver.sv - directed scoreboard bench for merge_driver with a behavioural merge core
module tb_merge_driver;

    localparam int CNT_W      = 10;
    localparam int SETTLE_CYC = 4;

    typedef logic [31:0] word_q[$];

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             cfg_go = 1'b0;
    logic [CNT_W-1:0] cfg_len1 = '0;
    logic [CNT_W-1:0] cfg_len2 = '0;
    logic             in_valid = 1'b0;
    logic [31:0]      in_data = '0;
    logic             in_ready;
    logic [31:0]      fifo_wr_data;
    logic             fifo1_wr_en;
    logic             fifo2_wr_en;
    logic             merge_start;
    logic             merge_done;
    logic             merged_rd_en;
    logic [31:0]      merged_rd_data;
    logic             out_valid;
    logic [31:0]      out_data;
    logic             out_last;
    logic             out_ready = 1'b1;
    logic             busy;
    logic             job_done;

    always #5 clock = ~clock;

    merge_driver #(.CNT_W(CNT_W), .SETTLE_CYC(SETTLE_CYC)) dut (
        .clock(clock), .reset(reset), .cfg_go(cfg_go), .cfg_len1(cfg_len1), .cfg_len2(cfg_len2),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .fifo_wr_data(fifo_wr_data), .fifo1_wr_en(fifo1_wr_en), .fifo2_wr_en(fifo2_wr_en),
        .merge_start(merge_start), .merge_done(merge_done),
        .merged_rd_en(merged_rd_en), .merged_rd_data(merged_rd_data),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
        .busy(busy), .job_done(job_done)
    );

    int n_cmp = 0;
    int n_err = 0;
    int rd_cnt, jd_cnt, out_cnt, last_cnt, ms_cycles, ov_seen, since_wr, gap_meas;
    bit prev_ms;
    logic [32:0] exp_wr[$];
    word_q exp_out;
    logic [32:0] e_wr;
    logic [31:0] e_out;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic word_q merge_runs(word_q a, word_q b);
        word_q r;
        while (a.size() > 0 || b.size() > 0) begin
            if (b.size() == 0 || (a.size() > 0 && a[0] <= b[0])) r.push_back(a.pop_front());
            else r.push_back(b.pop_front());
        end
        return r;
    endfunction

    // Merge core model: finishes a few cycles after merge_start, releases done once start drops.
    word_q f1, f2, mq;
    int    dly;
    always @(posedge clock) begin
        if (reset) begin
            f1.delete();
            f2.delete();
            mq.delete();
            dly            <= 0;
            merge_done     <= 1'b0;
            merged_rd_data <= '0;
        end else begin
            if (fifo1_wr_en) f1.push_back(fifo_wr_data);
            if (fifo2_wr_en) f2.push_back(fifo_wr_data);
            if (merge_start && !merge_done) begin
                if (dly == 3) begin
                    mq <= merge_runs(f1, f2);
                    f1.delete();
                    f2.delete();
                    merge_done <= 1'b1;
                    dly        <= 0;
                end else begin
                    dly <= dly + 1;
                end
            end else if (!merge_start && merge_done) begin
                merge_done <= 1'b0;
            end
            if (merged_rd_en) merged_rd_data <= mq.pop_front();
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            if (!reset) begin
                if (merge_start && !prev_ms) gap_meas = since_wr;
                prev_ms = merge_start;
                if (fifo1_wr_en && fifo2_wr_en) check("wr_en_exclusive", 1, 0);
                if (fifo1_wr_en || fifo2_wr_en) begin
                    if (exp_wr.size() == 0) check("wr_unexpected", 1, 0);
                    else begin
                        e_wr = exp_wr.pop_front();
                        check("fifo_write", {fifo2_wr_en, fifo_wr_data}, e_wr);
                    end
                    since_wr = 0;
                end else begin
                    since_wr++;
                end
                if (merge_start) ms_cycles++;
                if (merged_rd_en) rd_cnt++;
                if (job_done) jd_cnt++;
                if (out_valid) ov_seen++;
                if (out_valid && out_ready) begin
                    out_cnt++;
                    if (out_last) last_cnt++;
                    if (exp_out.size() == 0) check("out_unexpected", 1, 0);
                    else begin
                        e_out = exp_out.pop_front();
                        check("out_data", out_data, e_out);
                        check("out_last", out_last, exp_out.size() == 0);
                    end
                end
            end else begin
                prev_ms = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic clear_counts();
        rd_cnt = 0; jd_cnt = 0; out_cnt = 0; last_cnt = 0;
        ms_cycles = 0; ov_seen = 0; since_wr = 1000; gap_meas = -1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1; cfg_go = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (n) step();
        reset = 1'b0;
        exp_wr.delete();
        exp_out.delete();
        clear_counts();
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ctrl"}, {in_ready, fifo1_wr_en, fifo2_wr_en, merge_start, merged_rd_en,
                               out_valid, out_last, busy, job_done}, 0);
        check({tag, "_out_data"}, out_data, 0);
        check({tag, "_wr_data"}, fifo_wr_data, 0);
    endtask

    task automatic feed_job(input word_q r1, input word_q r2, input bit toggle, input int glitch_idx);
        word_q all;
        int t;
        clear_counts();
        foreach (r1[i]) begin exp_wr.push_back({1'b0, r1[i]}); all.push_back(r1[i]); end
        foreach (r2[i]) begin exp_wr.push_back({1'b1, r2[i]}); all.push_back(r2[i]); end
        cfg_go = 1'b1; cfg_len1 = CNT_W'(r1.size()); cfg_len2 = CNT_W'(r2.size());
        step();
        cfg_go = 1'b0;
        foreach (all[k]) begin
            in_valid = 1'b1;
            in_data  = all[k];
            if (k == glitch_idx) begin
                cfg_go = 1'b1; cfg_len1 = 5; cfg_len2 = 5;
            end
            t = 0;
            while (!in_ready && t < 200) begin step(); t++; end
            check("in_ready_timeout", t < 200, 1);
            step();
            cfg_go = 1'b0;
            if (toggle) begin in_valid = 1'b0; step(); end
        end
        in_valid = 1'b0;
    endtask

    task automatic finish_job(input int total, input int n1, input int stall_idx);
        int t;
        logic [31:0] hold;
        if (stall_idx >= 0) begin
            t = 0;
            while (out_cnt < stall_idx && t < 500) begin step(); t++; end
            out_ready = 1'b0;
            t = 0;
            while (!out_valid && t < 100) begin step(); t++; end
            check("stall_wait_timeout", t < 100, 1);
            hold = out_data;
            repeat (5) begin
                step();
                check("stall_data_stable", out_data, hold);
                check("stall_valid_held", out_valid, 1);
            end
            out_ready = 1'b1;
        end
        t = 0;
        while (jd_cnt == 0 && t < 3000) begin step(); t++; end
        check("job_done_timeout", t < 3000, 1);
        repeat (5) step();
        check("busy_after_job", busy, 0);
        check("job_done_pulses", jd_cnt, 1);
        check("rd_en_pulses", rd_cnt, total);
        check("out_count", out_cnt, total);
        check("out_last_count", last_cnt, (total > 0) ? 1 : 0);
        check("scoreboard_out_left", exp_out.size(), 0);
        check("scoreboard_wr_left", exp_wr.size(), 0);
        check("fifo_writes_total", total, n1 + (total - n1));
    endtask

    initial begin
        word_q a, b, x;
        int t;

        do_reset(3);
        check_idle_outputs("reset");

        a = {32'd1, 32'd4, 32'd9}; b = {32'd2, 32'd3, 32'd10};
        feed_job(a, b, 1'b0, -1);
        exp_out = {32'd1, 32'd2, 32'd3, 32'd4, 32'd9, 32'd10};
        finish_job(6, 3, -1);
        check("settle_gap", gap_meas, SETTLE_CYC);

        a.delete(); b = {32'd7, 32'd5};
        feed_job(a, b, 1'b0, -1);
        exp_out = {32'd7, 32'd5};
        finish_job(2, 0, -1);

        a.delete(); b.delete();
        feed_job(a, b, 1'b0, -1);
        exp_out.delete();
        finish_job(0, 0, -1);
        check("empty_merge_start_seen", ms_cycles > 0, 1);
        check("empty_no_out_valid", ov_seen, 0);

        a = {32'd2, 32'd5, 32'd8}; b = {32'd1, 32'd6};
        feed_job(a, b, 1'b1, -1);
        exp_out = {32'd1, 32'd2, 32'd5, 32'd6, 32'd8};
        finish_job(5, 3, 1);

        a = {32'd3, 32'd9}; b = {32'd4};
        feed_job(a, b, 1'b0, -1);
        t = 0;
        while (!merge_start && t < 200) begin step(); t++; end
        check("midjob_start_timeout", t < 200, 1);
        step();
        check("midjob_busy", busy, 1);
        do_reset(2);
        check_idle_outputs("midjob_reset");
        repeat (10) step();
        check("midjob_no_job_done", jd_cnt, 0);
        check("midjob_no_rd_en", rd_cnt, 0);
        check("midjob_idle", busy, 0);

        a = {32'd8}; b = {32'd6};
        feed_job(a, b, 1'b0, -1);
        exp_out = {32'd6, 32'd8};
        finish_job(2, 1, -1);

        a = {32'd3}; b = {32'd1, 32'd4};
        feed_job(a, b, 1'b0, 1);
        exp_out = {32'd1, 32'd3, 32'd4};
        finish_job(3, 1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
